// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter_if
// Brief    : CPU, DMA and dmem signal bundle for the data-memory port arbiter.
// Revision : 1.0
// ============================================================================
interface dmem_port_arbiter_if;
    logic        cpu_en;
    logic [3:0]  cpu_we;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;

    logic        dma_req_valid;
    logic        dma_req_ready;
    logic [3:0]  dma_we;
    logic [13:0] dma_addr;
    logic [31:0] dma_din;
    logic        dma_rsp_valid;
    logic        dma_rsp_ready;
    logic [31:0] dma_rsp_data;

    logic        mem_en;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic        dma_starve;
    logic [31:0] dma_grants;

    // Arbiter side
    modport slave (
        input  cpu_en, cpu_we, cpu_addr, cpu_din,
        output cpu_dout,
        input  dma_req_valid, dma_we, dma_addr, dma_din, dma_rsp_ready,
        output dma_req_ready, dma_rsp_valid, dma_rsp_data,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout,
        output dma_starve, dma_grants
    );

    // Requester / memory side
    modport master (
        output cpu_en, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout,
        output dma_req_valid, dma_we, dma_addr, dma_din, dma_rsp_ready,
        input  dma_req_ready, dma_rsp_valid, dma_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout,
        input  dma_starve, dma_grants
    );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Brief    : Shares the dmem port between the CPU (absolute priority) and DMA.
// Revision : 1.0
// ============================================================================
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 255,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    dmem_port_arbiter_if.slave  io_bus
);

    localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic             r_rd_pending;
    logic             r_rsp_full;
    logic [31:0]      r_rsp_data;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_starve;
    logic [31:0]      r_grants;

    logic             w_dma_is_rd;
    logic             w_dma_ready;
    logic             w_dma_accept;
    logic [CNT_W-1:0] w_starve_nxt;
    logic             w_mem_en;
    logic [3:0]       w_mem_we;
    logic [13:0]      w_mem_addr;
    logic [31:0]      w_mem_din;

    // Reads also need a free response slot; ready never looks at req_valid.
    always_comb begin
        w_dma_is_rd  = (io_bus.dma_we == 4'b0000);
        w_dma_ready  = !io_bus.cpu_en &&
                       (!w_dma_is_rd ||
                        (!r_rd_pending && (!r_rsp_full || io_bus.dma_rsp_ready)));
        w_dma_accept = io_bus.dma_req_valid && w_dma_ready;
    end

    always_comb begin
        w_mem_en   = 1'b0;
        w_mem_we   = 4'b0000;
        w_mem_addr = 14'd0;
        w_mem_din  = 32'd0;
        if (io_bus.cpu_en) begin
            w_mem_en   = 1'b1;
            w_mem_we   = io_bus.cpu_we;
            w_mem_addr = io_bus.cpu_addr;
            w_mem_din  = io_bus.cpu_din;
        end else if (w_dma_accept) begin
            w_mem_en   = 1'b1;
            w_mem_we   = io_bus.dma_we;
            w_mem_addr = io_bus.dma_addr;
            w_mem_din  = io_bus.dma_din;
        end
    end

    // Backpressure-only stalls leave the count untouched.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_dma_accept || !io_bus.dma_req_valid) begin
            w_starve_nxt = '0;
        end else if (io_bus.cpu_en && (r_starve_cnt != c_STARVE_MAX)) begin
            w_starve_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pending <= 1'b0;
            r_rsp_full   <= 1'b0;
            r_rsp_data   <= 32'd0;
            r_starve_cnt <= '0;
            r_starve     <= 1'b0;
            r_grants     <= 32'd0;
        end else begin
            r_rd_pending <= w_dma_accept && w_dma_is_rd;
            if (r_rd_pending) begin
                r_rsp_full <= 1'b1;
                r_rsp_data <= io_bus.mem_dout;
            end else if (r_rsp_full && io_bus.dma_rsp_ready) begin
                r_rsp_full <= 1'b0;
            end
            r_starve_cnt <= w_starve_nxt;
            r_starve     <= (w_starve_nxt == c_STARVE_MAX);
            if (w_dma_accept) begin
                r_grants <= r_grants + 32'd1;
            end
        end
    end

    assign io_bus.cpu_dout      = io_bus.mem_dout;
    assign io_bus.dma_req_ready = w_dma_ready;
    assign io_bus.dma_rsp_valid = r_rsp_full;
    assign io_bus.dma_rsp_data  = r_rsp_data;
    assign io_bus.mem_en        = w_mem_en;
    assign io_bus.mem_we        = w_mem_we;
    assign io_bus.mem_addr      = w_mem_addr;
    assign io_bus.mem_din       = w_mem_din;
    assign io_bus.dma_starve    = r_starve;
    assign io_bus.dma_grants    = r_grants;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Brief    : Directed vector table plus hand-written sequences for the arbiter.
// Revision : 1.0
// ============================================================================
module tb_dmem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter_if bus ();

    dmem_port_arbiter #(
        .STARVE_LIMIT (3),
        .CNT_W        (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    // Byte-writable dmem model with 1-cycle read-first synchronous read
    logic [31:0] mem [0:16383];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_dout <= mem[bus.mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        cpu_en;
        logic [3:0]  cpu_we;
        logic [13:0] cpu_addr;
        logic [31:0] cpu_din;
        logic        dma_v;
        logic [3:0]  dma_we;
        logic [13:0] dma_addr;
        logic [31:0] dma_din;
        logic        e_ready;
        logic        e_en;
        logic [3:0]  e_we;
        logic [13:0] e_addr;
        logic [31:0] e_din;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_en        = 1'b0;
        bus.cpu_we        = 4'h0;
        bus.cpu_addr      = 14'd0;
        bus.cpu_din       = 32'd0;
        bus.dma_req_valid = 1'b0;
        bus.dma_we        = 4'h0;
        bus.dma_addr      = 14'd0;
        bus.dma_din       = 32'd0;
        bus.dma_rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            cpu: en we    addr      din           dma: v we    addr      din           exp: rdy en we    addr      din
        vt[0] = '{1'b0, 4'h0, 14'h000, 32'h00000000, 1'b0, 4'h0, 14'h000, 32'h00000000, 1'b1, 1'b0, 4'h0, 14'h000, 32'h00000000};
        vt[1] = '{1'b1, 4'hF, 14'h021, 32'h11223344, 1'b1, 4'h0, 14'h020, 32'h00000000, 1'b0, 1'b1, 4'hF, 14'h021, 32'h11223344};
        vt[2] = '{1'b1, 4'h0, 14'h055, 32'hAAAA5555, 1'b0, 4'h0, 14'h000, 32'h00000000, 1'b0, 1'b1, 4'h0, 14'h055, 32'hAAAA5555};
        vt[3] = '{1'b0, 4'h0, 14'h000, 32'h00000000, 1'b1, 4'h3, 14'h123, 32'hCAFEF00D, 1'b1, 1'b1, 4'h3, 14'h123, 32'hCAFEF00D};
        vt[4] = '{1'b0, 4'h0, 14'h000, 32'h00000000, 1'b1, 4'h0, 14'h3FFF, 32'h0BADF00D, 1'b1, 1'b1, 4'h0, 14'h3FFF, 32'h0BADF00D};
        vt[5] = '{1'b0, 4'h0, 14'h000, 32'h00000000, 1'b0, 4'h5, 14'h007, 32'h12345678, 1'b1, 1'b0, 4'h0, 14'h000, 32'h00000000};
        vt[6] = '{1'b1, 4'hF, 14'h3FFF, 32'hFFFFFFFF, 1'b1, 4'hF, 14'h001, 32'h00000001, 1'b0, 1'b1, 4'hF, 14'h3FFF, 32'hFFFFFFFF};

        idle();
        bus.mem_dout = 32'd0;
        step();

        // Reset state
        do_reset();
        #2;
        chk("rst_rsp_valid", 32'(bus.dma_rsp_valid), 32'd0);
        chk("rst_starve",    32'(bus.dma_starve),    32'd0);
        chk("rst_grants",    bus.dma_grants,         32'd0);
        chk("rst_rsp_data",  bus.dma_rsp_data,       32'd0);

        // Port mux vectors, each from a freshly reset block
        for (int i = 0; i < 7; i++) begin
            do_reset();
            bus.cpu_en        = vt[i].cpu_en;
            bus.cpu_we        = vt[i].cpu_we;
            bus.cpu_addr      = vt[i].cpu_addr;
            bus.cpu_din       = vt[i].cpu_din;
            bus.dma_req_valid = vt[i].dma_v;
            bus.dma_we        = vt[i].dma_we;
            bus.dma_addr      = vt[i].dma_addr;
            bus.dma_din       = vt[i].dma_din;
            #2;
            chk($sformatf("vec%0d_ready", i), 32'(bus.dma_req_ready), 32'(vt[i].e_ready));
            chk($sformatf("vec%0d_en", i),    32'(bus.mem_en),        32'(vt[i].e_en));
            chk($sformatf("vec%0d_we", i),    32'(bus.mem_we),        32'(vt[i].e_we));
            chk($sformatf("vec%0d_addr", i),  32'(bus.mem_addr),      32'(vt[i].e_addr));
            chk($sformatf("vec%0d_din", i),   bus.mem_din,            vt[i].e_din);
            step();
        end

        // DMA write then read of 0x10
        do_reset();
        bus.dma_req_valid = 1'b1;
        bus.dma_we        = 4'hF;
        bus.dma_addr      = 14'h010;
        bus.dma_din       = 32'hDEADBEEF;
        bus.dma_rsp_ready = 1'b1;
        #2 chk("rd_wr_ready", 32'(bus.dma_req_ready), 32'd1);
        step();
        bus.dma_we = 4'h0;
        #2 chk("rd_c0_ready", 32'(bus.dma_req_ready), 32'd1);
        step();
        #2;
        chk("rd_c1_ready_pending", 32'(bus.dma_req_ready), 32'd0);
        chk("rd_c1_rsp_valid",     32'(bus.dma_rsp_valid), 32'd0);
        bus.dma_req_valid = 1'b0;
        step();
        #2;
        chk("rd_c2_rsp_valid", 32'(bus.dma_rsp_valid), 32'd1);
        chk("rd_c2_rsp_data",  bus.dma_rsp_data,       32'hDEADBEEF);
        chk("rd_grants",       bus.dma_grants,         32'd2);
        step();
        #2 chk("rd_c3_rsp_valid", 32'(bus.dma_rsp_valid), 32'd0);

        // CPU write conflicts with DMA read of the same word
        do_reset();
        bus.dma_req_valid = 1'b1;
        bus.dma_we        = 4'h0;
        bus.dma_addr      = 14'h020;
        bus.dma_rsp_ready = 1'b1;
        bus.cpu_en        = 1'b1;
        bus.cpu_we        = 4'hF;
        bus.cpu_addr      = 14'h020;
        bus.cpu_din       = 32'h11223344;
        for (int i = 0; i < 5; i++) begin
            #2 chk($sformatf("cf_blocked%0d", i), 32'(bus.dma_req_ready), 32'd0);
            step();
        end
        bus.cpu_en = 1'b0;
        #2;
        chk("cf_accept_ready", 32'(bus.dma_req_ready), 32'd1);
        chk("cf_accept_addr",  32'(bus.mem_addr),      32'h020);
        step();
        bus.dma_req_valid = 1'b0;
        step();
        #2;
        chk("cf_rsp_valid", 32'(bus.dma_rsp_valid), 32'd1);
        chk("cf_rsp_data",  bus.dma_rsp_data,       32'h11223344);
        chk("cf_grants",    bus.dma_grants,         32'd1);
        bus.cpu_en   = 1'b1;
        bus.cpu_we   = 4'h0;
        bus.cpu_addr = 14'h020;
        step();
        bus.cpu_en = 1'b0;
        #2 chk("cf_cpu_readback", bus.cpu_dout, 32'h11223344);

        // Response backpressure for 4 cycles
        do_reset();
        bus.dma_req_valid = 1'b1;
        bus.dma_we        = 4'h0;
        bus.dma_addr      = 14'h010;
        bus.dma_rsp_ready = 1'b0;
        #2 chk("bp_first_ready", 32'(bus.dma_req_ready), 32'd1);
        step();
        bus.dma_addr = 14'h020;
        #2;
        chk("bp_pending_ready", 32'(bus.dma_req_ready), 32'd0);
        chk("bp_pending_valid", 32'(bus.dma_rsp_valid), 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("bp_hold_valid%0d", i), 32'(bus.dma_rsp_valid), 32'd1);
            chk($sformatf("bp_hold_data%0d", i),  bus.dma_rsp_data,       32'hDEADBEEF);
            chk($sformatf("bp_hold_ready%0d", i), 32'(bus.dma_req_ready), 32'd0);
            step();
        end
        bus.dma_rsp_ready = 1'b1;
        #2;
        chk("bp_release_ready", 32'(bus.dma_req_ready), 32'd1);
        chk("bp_release_data",  bus.dma_rsp_data,       32'hDEADBEEF);
        step();
        bus.dma_req_valid = 1'b0;
        #2 chk("bp_drained_valid", 32'(bus.dma_rsp_valid), 32'd0);
        step();
        #2;
        chk("bp_second_valid", 32'(bus.dma_rsp_valid), 32'd1);
        chk("bp_second_data",  bus.dma_rsp_data,       32'h11223344);
        chk("bp_grants",       bus.dma_grants,         32'd2);

        // Starvation with a limit of 3
        do_reset();
        bus.cpu_en        = 1'b1;
        bus.dma_req_valid = 1'b1;
        bus.dma_we        = 4'h0;
        bus.dma_addr      = 14'h010;
        bus.dma_rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2 chk($sformatf("st_cycle%0d", i), 32'(bus.dma_starve), (i >= 3) ? 32'd1 : 32'd0);
            step();
        end
        bus.cpu_en = 1'b0;
        #2;
        chk("st_accept_ready",  32'(bus.dma_req_ready), 32'd1);
        chk("st_accept_starve", 32'(bus.dma_starve),    32'd1);
        step();
        bus.dma_req_valid = 1'b0;
        #2 chk("st_cleared", 32'(bus.dma_starve), 32'd0);
        step();

        // Reset in the cycle after an accepted read
        do_reset();
        bus.dma_req_valid = 1'b1;
        bus.dma_we        = 4'h0;
        bus.dma_addr      = 14'h010;
        bus.dma_rsp_ready = 1'b1;
        #2 chk("rm_ready", 32'(bus.dma_req_ready), 32'd1);
        step();
        bus.dma_req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2 chk($sformatf("rm_no_rsp%0d", i), 32'(bus.dma_rsp_valid), 32'd0);
            step();
        end
        chk("rm_grants",   bus.dma_grants,      32'd0);
        chk("rm_starve",   32'(bus.dma_starve), 32'd0);
        chk("rm_rsp_data", bus.dma_rsp_data,    32'd0);

        // Read accepted in the same cycle as reset is discarded
        bus.dma_req_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.dma_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2 chk($sformatf("rs_no_rsp%0d", i), 32'(bus.dma_rsp_valid), 32'd0);
            step();
        end
        chk("rs_grants", bus.dma_grants, 32'd0);

        // Byte-lane DMA write then CPU read
        do_reset();
        bus.dma_req_valid = 1'b1;
        bus.dma_we        = 4'hF;
        bus.dma_addr      = 14'h030;
        bus.dma_din       = 32'h12345678;
        step();
        bus.dma_we  = 4'b0100;
        bus.dma_din = 32'h00AB0000;
        step();
        bus.dma_req_valid = 1'b0;
        bus.cpu_en        = 1'b1;
        bus.cpu_we        = 4'h0;
        bus.cpu_addr      = 14'h030;
        step();
        bus.cpu_en = 1'b0;
        #2;
        chk("bw_cpu_dout", bus.cpu_dout,   32'h12AB5678);
        chk("bw_grants",   bus.dma_grants, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (dmem: 14-bit word address, 4-bit byte write enable, 1-cycle synchronous read) between the CPU memory stage and a DMA requester.
- The CPU has absolute priority and is never stalled, because the pipeline has no stall path.
- The DMA side uses a valid/ready request channel and a buffered valid/ready response channel.
- The block also provides a starvation flag and a grant counter, exposed through the MMIO counter space.

Parameters:
- STARVE_LIMIT, default 255: number of consecutive blocked DMA cycles at which dma_starve asserts; the counter saturates there.
- CNT_W, default 8: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- cpu_en  input  1  CPU accesses dmem this cycle
- cpu_we  input  4  CPU byte write enable
- cpu_addr  input  14  CPU word address
- cpu_din  input  32  CPU write data
- cpu_dout  output  32  read data to the CPU, equal to mem_dout
- dma_req_valid  input  1  DMA request present
- dma_req_ready  output  1  DMA request accepted this cycle
- dma_we  input  4  DMA byte write enable; 0 means a read
- dma_addr  input  14  DMA word address
- dma_din  input  32  DMA write data
- dma_rsp_valid  output  1  DMA read data available
- dma_rsp_ready  input  1  DMA consumes the response
- dma_rsp_data  output  32  DMA read data
- mem_en  output  1  to dmem.en
- mem_we  output  4  to dmem.we
- mem_addr  output  14  to dmem.addr
- mem_din  output  32  to dmem.din
- mem_dout  input  32  from dmem.dout
- dma_starve  output  1  DMA blocked for STARVE_LIMIT consecutive cycles
- dma_grants  output  32  count of accepted DMA requests, wraps

Behaviour:
- Reset (synchronous, active-high): rd_pending=0, rsp_full=0, rsp_data=0, starve_cnt=0, dma_grants=0. A read accepted in the same cycle as rst is discarded and no response is produced. Outputs after reset: dma_rsp_valid=0, dma_starve=0, dma_grants=0, dma_rsp_data=0.
- Port mux (combinational):
  - cpu_en=1: mem_* = cpu_*; dma_req_ready=0.
  - Otherwise, if DMA is accepted: mem_en=1, mem_we=dma_we, mem_addr=dma_addr, mem_din=dma_din.
  - Otherwise: mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
- cpu_dout = mem_dout unconditionally. The CPU only samples it in the cycle after its own access.
- DMA write acceptance: dma_req_ready = !cpu_en. Writes produce no response.
- DMA read acceptance: dma_req_ready = !cpu_en && !rd_pending && (!rsp_full || dma_rsp_ready). Peak read throughput is one read every 2 cycles.
- dma_req_ready never depends on dma_req_valid, so there is no combinational loop.
- DMA must hold its request stable while dma_req_valid && !dma_req_ready. The block does not check this.
- rd_pending is set in the cycle after an accepted read and lasts exactly 1 cycle. In that cycle: rsp_data <= mem_dout and rsp_full <= 1.
- dma_rsp_valid = rsp_full (registered), so latency is 2 cycles from accept edge to rsp_valid.
- rsp_full clears on dma_rsp_valid && dma_rsp_ready, unless a capture happens in the same cycle, in which case it stays 1 with the new data.
- rsp_data is held stable while valid && !ready.
- Starvation:
  - starve_cnt increments (saturating at STARVE_LIMIT) each cycle with dma_req_valid && cpu_en.
  - It clears on any cycle with DMA acceptance or with dma_req_valid=0.
  - It holds on cycles blocked only by response backpressure.
  - dma_starve = (starve_cnt == STARVE_LIMIT), registered.
- dma_grants increments by 1 on each cycle with dma_req_valid && dma_req_ready, wrapping at 2^32.
- Simultaneous CPU and DMA requests: the CPU always wins and the DMA request stays pending. No CPU transaction is ever dropped or delayed.

Test Plan:
- DMA read alone: write 0xDEADBEEF at addr 0x10 via the DMA path, then issue a DMA read of 0x10 with rsp_ready=1 → ready=1 at cycle 0, rsp_valid=1 at cycle 2 with data 0xDEADBEEF, dma_grants=2.
- Conflict: cpu_en=1 for 5 cycles writing 0x11223344 to 0x20 while a DMA read of 0x20 is valid → dma_req_ready=0 for 5 cycles, then accepted, rsp_data=0x11223344, and the CPU write lands unmodified.
- Backpressure: DMA read with rsp_ready=0 for 4 cycles → rsp_valid stays 1 with stable data, a second read is not accepted until the cycle rsp_ready=1, and no data is lost.
- Starvation: STARVE_LIMIT=3, cpu_en held high, DMA valid → dma_starve=1 on the cycle after the third blocked cycle, clears one cycle after DMA acceptance.
- Reset mid-read: assert rst in the cycle after a DMA read is accepted → dma_rsp_valid never asserts, and all counters and flags are 0.
- Byte write: DMA write we=0b0100 data 0x00AB0000 to a word holding 0x12345678, then a CPU read → cpu_dout=0x12AB5678.
